// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, bit positions,
// MTC0 write masks and the exception-code decode helpers.
package cp0_regfile_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Resolved exception codes delivered by the Memory stage
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Status / Cause bit positions
    localparam int STATUS_EXL  = 1;
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    // Software-writable bits
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // What a resolved exception code does to architectural state
    typedef enum logic [1:0] {
        EXC_ACT_NONE,   // no exception: MTC0 may proceed
        EXC_ACT_TRAP,   // take exception: EPC/Cause/EXL update
        EXC_ACT_ERET,   // return: clear EXL only
        EXC_ACT_DROP    // unknown code: instruction flushed, no state change
    } exc_act_e;

    function automatic exc_act_e exc_action(input logic [31:0] et);
        exc_act_e act;
        case (et)
            EXC_NONE: act = EXC_ACT_NONE;
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BP, EXC_RI, EXC_OV:
                      act = EXC_ACT_TRAP;
            EXC_ERET: act = EXC_ACT_ERET;
            default:  act = EXC_ACT_DROP;
        endcase
        return act;
    endfunction

    // ExcCode field value; the interrupt request maps to code 0
    function automatic logic [4:0] exc_code(input logic [31:0] et);
        logic [4:0] code;
        case (et)
            EXC_INT: code = 5'h00;
            default: code = et[4:0];
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register file and timer: holds Status/Cause/EPC/BadVAddr/Count/Compare,
// commits Memory-stage exceptions and services MTC0/MFC0.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  ext_int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] badaddr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;
    logic        phase_q, phase_d;

    exc_act_e    act_s;
    logic        mtc0_en_s;
    logic        count_inc_s;

    // Decode the exception action; an MTC0 only lands when nothing is flushing
    always_comb begin
        act_s       = exc_action(excepttype_i);
        mtc0_en_s   = we_i && (act_s == EXC_ACT_NONE);
        count_inc_s = (COUNT_DIV == 1) ? 1'b1 : phase_q;
    end

    // Next-state for Count divider, timer, MTC0 writes and exception commit
    always_comb begin
        status_d    = status_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        badvaddr_d  = badvaddr_q;
        compare_d   = compare_q;
        phase_d     = ~phase_q;

        // Count: a software load restarts the divider and skips this increment
        if (mtc0_en_s && (waddr_i == CP0_COUNT)) begin
            count_d = wdata_i;
            phase_d = 1'b0;
        end else if (count_inc_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        // Timer: match uses pre-increment Count; a Compare write clears and wins
        if (mtc0_en_s && (waddr_i == CP0_COMPARE)) begin
            timer_int_d = 1'b0;
        end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end else begin
            timer_int_d = timer_int_q;
        end

        case (act_s)
            EXC_ACT_TRAP: begin
                cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code(excepttype_i);
                if (!status_q[STATUS_EXL]) begin
                    epc_d             = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    cause_d[CAUSE_BD] = in_delayslot_i;
                end else begin
                    epc_d = epc_q;
                end
                status_d[STATUS_EXL] = 1'b1;
                if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
                    badvaddr_d = badaddr_i;
                end else begin
                    badvaddr_d = badvaddr_q;
                end
            end
            EXC_ACT_ERET: begin
                status_d[STATUS_EXL] = 1'b0;
            end
            EXC_ACT_NONE: begin
                if (mtc0_en_s) begin
                    case (waddr_i)
                        CP0_STATUS:  status_d  = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                        CP0_CAUSE:   cause_d   = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
                        CP0_EPC:     epc_d     = wdata_i;
                        CP0_COMPARE: compare_d = wdata_i;
                        default:     compare_d = compare_q;
                    endcase
                end else begin
                    compare_d = compare_q;
                end
            end
            default: begin
                status_d = status_q;
            end
        endcase

        // Interrupt-pending bits track the lines every cycle, not writable
        cause_d[CAUSE_IP_HI:CAUSE_IP_LO] = {ext_int_i[5] | timer_int_q, ext_int_i[4:0]};
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q    <= STATUS_RST;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            badvaddr_q  <= 32'd0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            badvaddr_q  <= badvaddr_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
            phase_q     <= phase_d;
        end
    end

    // MFC0 read mux: current register contents, no bypass of a pending write
    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_q;
            CP0_COUNT:    rdata_o = count_q;
            CP0_COMPARE:  rdata_o = compare_q;
            CP0_STATUS:   rdata_o = status_q;
            CP0_CAUSE:    rdata_o = cause_q;
            CP0_EPC:      rdata_o = epc_q;
            default:      rdata_o = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations are queued as stimulus is
// driven and compared once the DUT has taken the edge (or settled).
module tb_cp0_regfile;

    logic        clk;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  ext_int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] badaddr_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    localparam int S_STATUS  = 0;
    localparam int S_CAUSE   = 1;
    localparam int S_EPC     = 2;
    localparam int S_COUNT   = 3;
    localparam int S_COMPARE = 4;
    localparam int S_TIMER   = 5;
    localparam int S_RDATA   = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    cp0_regfile #(
        .STATUS_RST (32'h0040_0000),
        .COUNT_DIV  (2)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .ext_int_i      (ext_int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .badaddr_i      (badaddr_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .timer_int_o    (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATUS:  return status_o;
            S_CAUSE:   return cause_o;
            S_EPC:     return epc_o;
            S_COUNT:   return count_o;
            S_COMPARE: return compare_o;
            S_TIMER:   return {31'd0, timer_int_o};
            S_RDATA:   return rdata_o;
            default:   return 32'hDEAD_DEAD;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic idle();
        we_i           = 1'b0;
        waddr_i        = 5'd0;
        wdata_i        = 32'd0;
        excepttype_i   = 32'd0;
        pc_i           = 32'd0;
        in_delayslot_i = 1'b0;
        badaddr_i      = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = r;
        wdata_i = d;
    endtask

    task automatic raise(input logic [31:0] et, input logic [31:0] pc, input logic dly, input logic [31:0] bad);
        excepttype_i   = et;
        pc_i           = pc;
        in_delayslot_i = dly;
        badaddr_i      = bad;
    endtask

    logic [4:0]  rd_regs [7];
    logic [31:0] rd_exp  [7];

    initial begin
        clk       = 1'b0;
        resetn    = 1'b0;
        raddr_i   = 5'd0;
        ext_int_i = 6'd0;
        idle();

        // Reset contents via MFC0 and outputs
        rd_regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        rd_exp  = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0, 32'd0};
        #2;
        for (int i = 0; i < 7; i++) begin
            raddr_i = rd_regs[i];
            expect_v($sformatf("rst_rd%0d", rd_regs[i]), S_RDATA, rd_exp[i]);
            settle();
        end
        expect_v("rst_timer", S_TIMER, 32'd0);
        expect_v("rst_status", S_STATUS, 32'h0040_0000);
        settle();

        // Count runs at half clock rate after release
        @(negedge clk);
        resetn = 1'b1;
        expect_v("cnt_1", S_COUNT, 32'd0);
        tick();
        repeat (8) tick();
        expect_v("cnt_10", S_COUNT, 32'd5);
        tick();

        // Timer match
        mtc0(5'd11, 32'h10);
        expect_v("cmp_wr", S_COMPARE, 32'h10);
        tick();
        mtc0(5'd9, 32'h0E);
        expect_v("cnt_wr", S_COUNT, 32'h0E);
        tick();
        idle();
        for (int i = 1; i <= 4; i++) begin
            expect_v($sformatf("tmr_lo%0d", i), S_TIMER, 32'd0);
            tick();
        end
        expect_v("tmr_set", S_TIMER, 32'd1);
        expect_v("tmr_ip_lag", S_CAUSE, 32'd0);
        tick();
        expect_v("tmr_ip", S_CAUSE, 32'h0000_8000);
        expect_v("tmr_hold", S_TIMER, 32'd1);
        tick();
        mtc0(5'd11, 32'h40);
        expect_v("tmr_clr", S_TIMER, 32'd0);
        expect_v("cmp_wr2", S_COMPARE, 32'h40);
        expect_v("tmr_ip_tail", S_CAUSE, 32'h0000_8000);
        tick();
        idle();
        expect_v("tmr_ip_clr", S_CAUSE, 32'd0);
        tick();

        // Load address error in a delay slot
        raise(32'h4, 32'hBFC0_1004, 1'b1, 32'h3);
        raddr_i = 5'd8;
        expect_v("adel_epc", S_EPC, 32'hBFC0_1000);
        expect_v("adel_cause", S_CAUSE, 32'h8000_0010);
        expect_v("adel_status", S_STATUS, 32'h0040_0002);
        expect_v("adel_badva", S_RDATA, 32'h3);
        tick();

        // Nested exception keeps EPC/BD, then ERET clears EXL
        raise(32'h8, 32'h100, 1'b0, 32'h0);
        expect_v("nest_epc", S_EPC, 32'hBFC0_1000);
        expect_v("nest_cause", S_CAUSE, 32'h8000_0020);
        tick();
        raise(32'he, 32'h200, 1'b0, 32'h0);
        expect_v("eret_status", S_STATUS, 32'h0040_0000);
        expect_v("eret_epc", S_EPC, 32'hBFC0_1000);
        tick();
        idle();

        // Write masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_v("st_mask", S_STATUS, 32'h0040_FF03);
        tick();
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_v("ca_mask", S_CAUSE, 32'h8000_0320);
        tick();
        mtc0(5'd8, 32'h1234_5678);
        expect_v("badva_ro", S_RDATA, 32'h3);
        tick();
        mtc0(5'd12, 32'h0);
        expect_v("st_clr", S_STATUS, 32'h0040_0000);
        tick();

        // MTC0 colliding with an exception is dropped
        mtc0(5'd14, 32'hDEAD_BEEF);
        raise(32'hc, 32'h2000, 1'b0, 32'h0);
        expect_v("coll_epc", S_EPC, 32'h0000_2000);
        expect_v("coll_cause", S_CAUSE, 32'h0000_0330);
        expect_v("coll_status", S_STATUS, 32'h0040_0002);
        tick();
        idle();

        // External interrupt lines and an unknown exception code
        ext_int_i = 6'h21;
        raise(32'h3, 32'h3000, 1'b1, 32'h77);
        expect_v("ext_ip", S_CAUSE, 32'h0000_8730);
        expect_v("unk_epc", S_EPC, 32'h0000_2000);
        expect_v("unk_status", S_STATUS, 32'h0040_0002);
        tick();
        idle();
        ext_int_i = 6'h00;
        expect_v("ext_ip_clr", S_CAUSE, 32'h0000_0330);
        tick();

        // Reset while the timer is pending and Count is running
        mtc0(5'd9, 32'h3E);
        tick();
        idle();
        repeat (4) tick();
        expect_v("tmr2_set", S_TIMER, 32'd1);
        tick();
        tick();
        #2;
        resetn = 1'b0;
        raddr_i = 5'd8;
        expect_v("mr_status", S_STATUS, 32'h0040_0000);
        expect_v("mr_cause", S_CAUSE, 32'd0);
        expect_v("mr_epc", S_EPC, 32'd0);
        expect_v("mr_count", S_COUNT, 32'd0);
        expect_v("mr_compare", S_COMPARE, 32'd0);
        expect_v("mr_timer", S_TIMER, 32'd0);
        expect_v("mr_badva", S_RDATA, 32'd0);
        settle();
        @(negedge clk);
        resetn = 1'b1;
        expect_v("mr_cnt0", S_COUNT, 32'd0);
        tick();
        expect_v("mr_cnt1", S_COUNT, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
